stream_seq: RTL and testbench
=============================

# stream_seq

Parametrised, synthesizable stream sequencer that replays a programmable list of input segments (seed, signature, key, message, hint, …) from a word memory into a core's valid/ready input port, inserts a programmable idle gap before each segment to emulate backpressure, captures the single-word result from the core's output port and records per-segment and total cycle counts. It generalises the hand-coded per-operation load sequences into one block usable for keygen, sign and verify on any security level. It sits between a test-vector RAM and the `dilithium` core on FPGA benches.

## Interface
- `W`, 64: stream and memory data width.
- `NUM_SEG`, 8: maximum number of segments.
- `ADDR_W`, 16: memory word address width.
- `LEN_W`, 16: segment length width, in words.
- `IDLE_W`, 16: idle-gap length width, in cycles.
- `CYC_W`, 32: cycle counter width.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run when in IDLE.
- `num_seg`  in  $clog2(NUM_SEG+1)  active segments (0..NUM_SEG).
- `seg_base`  in  NUM_SEG*ADDR_W  first word address of segment k, at bits [k*ADDR_W +: ADDR_W].
- `seg_len`  in  NUM_SEG*LEN_W  words in segment k; 0 means skip.
- `seg_idle`  in  NUM_SEG*IDLE_W  idle cycles inserted before segment k.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rdata`  in  W  read data, valid one cycle after `mem_en`.
- `out_valid`  out  1  word offered to core (core `valid_i`).
- `out_ready`  in  1  core accepts (core `ready_i`).
- `out_data`  out  W  word to core (core `data_i`).
- `res_valid`  in  1  core result valid (core `valid_o`).
- `res_ready`  out  1  block accepts result (core `ready_o`).
- `res_data`  in  W  core result (core `data_o`).
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when result captured.
- `result`  out  W  captured result word.
- `stat_sel`  in  $clog2(NUM_SEG)  selects segment for `stat_cycles`.
- `stat_cycles`  out  CYC_W  load cycles of selected segment.
- `total_cycles`  out  CYC_W  cycles from `start` to result capture.

## Operation
- States: IDLE, GAP, LOAD, RESULT. Segment index `k`, word counter `n`.
- IDLE: `start`=1 -> clear all stat counters and `total_cycles`, `k`=0; go to GAP if `num_seg`>0 else RESULT. `start` outside IDLE is ignored.
- GAP: count `seg_idle[k]` cycles with `out_valid`=0, `mem_en`=0; then LOAD. Segment with `seg_len[k]`=0: no gap, no load, stat stays 0, advance `k`.
- LOAD: read `seg_base[k]+n`, n=0..len-1, into a 2-entry buffer (output register + skid); `mem_en` asserted only if a slot is free accounting for the in-flight read. `out_data` is the buffer head; a word retires on `out_valid & out_ready`. Words leave strictly in address order, no duplicates or drops. After last word retires: `k`+1 < `num_seg` -> GAP of next non-empty segment, else RESULT.
- Address arithmetic modulo 2^ADDR_W (wraps).
- RESULT: `res_ready`=1; on `res_valid` latch `result`, pulse `done`, return to IDLE.
- Config inputs are held stable by the driver while `busy`=1; no latching.
- Counters saturate at 2^CYC_W-1. Segment counter runs from first LOAD cycle through the cycle the last word retires, inclusive.

## Timing
- Reset values: `mem_en`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `res_ready`=0, `busy`=0, `done`=0, `result`=0, `stat_cycles`=0, `total_cycles`=0, state IDLE.
- `busy` rises the cycle after `start` and falls with `done`.
- First `mem_en` on first LOAD cycle; `out_valid` two cycles later. With `out_ready` held high, one word per cycle: segment of L words takes L+2 cycles.
- `out_valid` never drops without acceptance while in LOAD; `out_data` stable while `out_valid & !out_ready`.
- `total_cycles` counts from the cycle after `start` through the `done` cycle, inclusive.
- `rst` mid-run: immediate return to reset values; in-flight memory data discarded.

## Test plan
- `num_seg`=1, base=0x10, len=4, idle=0, `out_ready`=1, result 0xA5 -> words mem[0x10..0x13] in order on 4 consecutive cycles, stat=6, `done` with `result`=0xA5.
- `out_ready` toggling 1,0,0,1… over len=8 -> all 8 words exactly once, in order, `out_data` held during stalls.
- 3 segments, len {2,0,3}, idle {5,7,1} -> segment 1 skipped (stat 0, no gap), exactly 5 and 1 idle cycles before segments 0 and 2.
- base=0xFFFE, len=4, ADDR_W=16 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- `num_seg`=0 -> straight to RESULT, `res_ready`=1 next cycle; `start` pulsed while busy ignored.
- `rst` asserted mid-LOAD -> all outputs at reset values that cycle; new `start` completes a clean run.

Source files
------------

// File: rtl/stream_seq.sv
// Stream sequencer: replays memory segments into a valid/ready port with
// programmable idle gaps, captures one result word and keeps cycle stats.
module stream_seq #(
   parameter int W       = 64,
   parameter int NUM_SEG = 8,
   parameter int ADDR_W  = 16,
   parameter int LEN_W   = 16,
   parameter int IDLE_W  = 16,
   parameter int CYC_W   = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [$clog2(NUM_SEG+1)-1:0] num_seg,
   input  logic [NUM_SEG*ADDR_W-1:0]   seg_base,
   input  logic [NUM_SEG*LEN_W-1:0]    seg_len,
   input  logic [NUM_SEG*IDLE_W-1:0]   seg_idle,
   output logic                        mem_en,
   output logic [ADDR_W-1:0]           mem_addr,
   input  logic [W-1:0]                mem_rdata,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [W-1:0]                out_data,
   input  logic                        res_valid,
   output logic                        res_ready,
   input  logic [W-1:0]                res_data,
   output logic                        busy,
   output logic                        done,
   output logic [W-1:0]                result,
   input  logic [$clog2(NUM_SEG)-1:0]  stat_sel,
   output logic [CYC_W-1:0]            stat_cycles,
   output logic [CYC_W-1:0]            total_cycles
);

   localparam int KW = $clog2(NUM_SEG);
   localparam int NW = $clog2(NUM_SEG+1);
   localparam logic [CYC_W-1:0] CMAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_LOAD,
      S_RES
   } state_t;

   state_t state, state_n;

   logic [KW-1:0]     k, k_n;
   logic [IDLE_W-1:0] gcnt, gcnt_n;
   logic [LEN_W-1:0]  n_req, n_ret;
   logic              inflight;
   logic [1:0]        cnt, occ;
   logic [W-1:0]      buf0, buf1;
   logic [CYC_W-1:0]  stat_q [NUM_SEG];
   logic [CYC_W-1:0]  total_q;
   logic              done_q;
   logic [W-1:0]      result_q;

   logic [LEN_W-1:0]  len_k;
   logic [ADDR_W-1:0] base_k;
   logic [NW-1:0]     scan;
   logic              hit;
   logic [KW-1:0]     hit_idx;
   logic [IDLE_W-1:0] hit_idle;
   logic              pop, last_ret, capture, go, kick;

   // Current segment fields and the next non-empty segment at or after scan
   always_comb begin
      len_k    = '0;
      base_k   = '0;
      hit      = 1'b0;
      hit_idx  = '0;
      hit_idle = '0;
      scan     = (state == S_IDLE) ? '0 : NW'(k) + NW'(1);
      for (int j = 0; j < NUM_SEG; j++) begin
         if (KW'(j) == k) begin
            len_k  = seg_len[j*LEN_W +: LEN_W];
            base_k = seg_base[j*ADDR_W +: ADDR_W];
         end
      end
      for (int j = NUM_SEG-1; j >= 0; j--) begin
         if (NW'(j) >= scan && NW'(j) < num_seg &&
             seg_len[j*LEN_W +: LEN_W] != '0) begin
            hit      = 1'b1;
            hit_idx  = KW'(j);
            hit_idle = seg_idle[j*IDLE_W +: IDLE_W];
         end
      end
   end

   assign out_valid = (cnt != 2'd0);
   assign out_data  = buf0;
   assign pop       = out_valid & out_ready;
   assign occ       = cnt + {1'b0, inflight};
   assign mem_en    = (state == S_LOAD) && (n_req < len_k) &&
                      ((occ < 2'd2) || pop);
   assign mem_addr  = mem_en ? base_k + ADDR_W'(n_req) : '0;
   assign last_ret  = pop && (n_ret == len_k - LEN_W'(1));
   assign res_ready = (state == S_RES);
   assign capture   = res_ready & res_valid;
   assign busy      = (state != S_IDLE);
   assign kick      = (state == S_IDLE) & start;
   assign done      = done_q;
   assign result    = result_q;
   assign total_cycles = total_q;
   assign stat_cycles  = stat_q[stat_sel];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      gcnt_n  = gcnt;
      go      = 1'b0;
      case (state)
         S_IDLE: go = start;
         S_GAP: begin
            if (gcnt == IDLE_W'(1)) state_n = S_LOAD;
            else                    gcnt_n  = gcnt - IDLE_W'(1);
         end
         S_LOAD: go = last_ret;
         S_RES: if (res_valid) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (go) begin
         if (hit) begin
            k_n     = hit_idx;
            gcnt_n  = hit_idle;
            state_n = (hit_idle == '0) ? S_LOAD : S_GAP;
         end else begin
            state_n = S_RES;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k        <= '0;
         gcnt     <= '0;
         n_req    <= '0;
         n_ret    <= '0;
         inflight <= 1'b0;
         cnt      <= 2'd0;
         buf0     <= '0;
         buf1     <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         k        <= k_n;
         gcnt     <= gcnt_n;
         inflight <= mem_en;
         done_q   <= capture;
         if (capture) result_q <= res_data;
         if (mem_en) n_req <= n_req + LEN_W'(1);
         if (pop)    n_ret <= n_ret + LEN_W'(1);
         if (last_ret) begin
            n_req <= '0;
            n_ret <= '0;
         end
         // Two-entry buffer, head in buf0
         case ({inflight, pop})
            2'b10: begin
               if (cnt == 2'd0) buf0 <= mem_rdata;
               else             buf1 <= mem_rdata;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               buf0 <= buf1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  buf0 <= mem_rdata;
               end else begin
                  buf0 <= buf1;
                  buf1 <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   // Capture cycle adds two so the done cycle itself is included
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         total_q <= '0;
         for (int j = 0; j < NUM_SEG; j++) stat_q[j] <= '0;
      end else if (kick) begin
         total_q <= '0;
         for (int j = 0; j < NUM_SEG; j++) stat_q[j] <= '0;
      end else begin
         if (capture)
            total_q <= (total_q >= CMAX - CYC_W'(1)) ? CMAX
                                                      : total_q + CYC_W'(2);
         else if (busy && total_q != CMAX)
            total_q <= total_q + CYC_W'(1);
         if (state == S_LOAD && stat_q[k] != CMAX)
            stat_q[k] <= stat_q[k] + CYC_W'(1);
      end
   end

endmodule

// File: tb/tb_stream_seq.sv
// Scoreboard bench for stream_seq: directed segment lists, expected words
// queued at stimulus time and checked by an independent monitor.
module tb_stream_seq;

   localparam int W = 64, NS = 8, AW = 16, LW = 16, IW = 16, CW = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [3:0]        num_seg = '0;
   logic [NS*AW-1:0]  seg_base = '0;
   logic [NS*LW-1:0]  seg_len = '0;
   logic [NS*IW-1:0]  seg_idle = '0;
   logic              mem_en;
   logic [AW-1:0]     mem_addr;
   logic [W-1:0]      mem_rdata = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [W-1:0]      out_data;
   logic              res_valid = 1'b0;
   logic              res_ready;
   logic [W-1:0]      res_data = '0;
   logic              busy, done;
   logic [W-1:0]      result;
   logic [2:0]        stat_sel = '0;
   logic [CW-1:0]     stat_cycles, total_cycles;

   int checks = 0, failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_res[$];
   int cyc = 0, ret_n = 0, done_n = 0, idle_cnt = 0;
   int first_en = -1, first_ret = -1, last_ret = -1, rise_cyc = -1;
   logic busy_prev = 1'b0, hold_prev = 1'b0;
   logic [W-1:0] hold_data = '0;
   logic rdy_pat = 1'b0;
   int pi = 0;

   stream_seq #(.W(W), .NUM_SEG(NS), .ADDR_W(AW), .LEN_W(LW),
                .IDLE_W(IW), .CYC_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_seg(num_seg),
      .seg_base(seg_base), .seg_len(seg_len), .seg_idle(seg_idle),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .done(done), .result(result), .stat_sel(stat_sel),
      .stat_cycles(stat_cycles), .total_cycles(total_cycles));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mdata(input logic [AW-1:0] a);
      return {48'hA5A5_0000_C0DE, a};
   endfunction

   always @(posedge clk) if (mem_en) mem_rdata <= mdata(mem_addr);

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_pat) begin
         out_ready = (pi == 0 || pi == 3);
         pi = (pi + 1) % 4;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (busy && !busy_prev) rise_cyc = cyc;
         busy_prev = busy;
         if (busy && !mem_en && !out_valid && !res_ready) idle_cnt++;
         if (mem_en && first_en < 0) first_en = cyc;
         if (out_valid && hold_prev) chk("hold", out_data, hold_data);
         hold_prev = out_valid && !out_ready;
         hold_data = out_data;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_word", out_data, '0);
            else chk("word", out_data, exp_q.pop_front());
            if (first_ret < 0) first_ret = cyc;
            last_ret = cyc;
            ret_n++;
         end
         if (done) begin
            done_n++;
            if (exp_res.size() == 0) chk("extra_done", result, '1);
            else chk("result", result, exp_res.pop_front());
         end
      end else begin
         hold_prev = 1'b0;
         busy_prev = 1'b0;
      end
   end

   task automatic clr_cfg();
      seg_base = '0;
      seg_len  = '0;
      seg_idle = '0;
      ret_n = 0; idle_cnt = 0; done_n = 0;
      first_en = -1; first_ret = -1; last_ret = -1; rise_cyc = -1;
   endtask

   task automatic set_seg(input int s, input logic [AW-1:0] b,
                          input int len, input int idl);
      seg_base[s*AW +: AW] = b;
      seg_len[s*LW +: LW]  = LW'(len);
      seg_idle[s*IW +: IW] = IW'(idl);
      for (int i = 0; i < len; i++) exp_q.push_back(mdata(b + AW'(i)));
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      chk(name, 64'(seen), 64'd1);
   endtask

   task automatic chk_stat(input int s, input int exp);
      stat_sel = 3'(s);
      #1 chk($sformatf("stat%0d", s), 64'(stat_cycles), 64'(exp));
   endtask

   task automatic simple_run(input logic [W-1:0] r);
      clr_cfg();
      num_seg = 4'd1;
      set_seg(0, 16'h0010, 4, 0);
      res_valid = 1'b1; res_data = r;
      exp_res.push_back(r);
      pulse_start();
      wait_done("t1_timeout");
      chk("t1_total", 64'(total_cycles), 64'd8);
      chk_stat(0, 6);
      chk("t1_lat", 64'(first_ret - first_en), 64'd2);
      chk("t1_b2b", 64'(last_ret - first_ret), 64'd3);
      chk("t1_count", 64'(ret_n), 64'd4);
   endtask

   initial begin
      #2;
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_total", 64'(total_cycles), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      simple_run(64'hA5);

      // Backpressure pattern 1,0,0,1
      clr_cfg();
      num_seg = 4'd1;
      set_seg(0, 16'h0040, 8, 0);
      res_data = 64'h5A5A; exp_res.push_back(64'h5A5A);
      pi = 0; rdy_pat = 1'b1;
      pulse_start();
      wait_done("t2_timeout");
      rdy_pat = 1'b0;
      @(posedge clk); #1 out_ready = 1'b1;
      chk("t2_count", 64'(ret_n), 64'd8);
      chk("t2_drain", 64'(exp_q.size()), 64'd0);

      // Three segments, middle one empty
      clr_cfg();
      num_seg = 4'd3;
      set_seg(0, 16'h0100, 2, 5);
      set_seg(1, 16'h0180, 0, 7);
      set_seg(2, 16'h0200, 3, 1);
      res_data = 64'h1234; exp_res.push_back(64'h1234);
      pulse_start();
      wait_done("t3_timeout");
      chk("t3_total", 64'(total_cycles), 64'd17);
      chk("t3_idle", 64'(idle_cnt), 64'd6);
      chk("t3_gap0", 64'(first_en - rise_cyc), 64'd5);
      chk_stat(0, 4);
      chk_stat(1, 0);
      chk_stat(2, 5);

      // Address wrap
      clr_cfg();
      num_seg = 4'd1;
      set_seg(0, 16'hFFFE, 4, 2);
      res_data = 64'hBEEF; exp_res.push_back(64'hBEEF);
      pulse_start();
      wait_done("t4_timeout");
      chk("t4_total", 64'(total_cycles), 64'd10);
      chk_stat(0, 6);
      chk("t4_count", 64'(ret_n), 64'd4);

      // No segments, start while busy ignored
      clr_cfg();
      num_seg = 4'd0;
      res_valid = 1'b0; res_data = 64'h77;
      exp_res.push_back(64'h77);
      pulse_start();
      @(negedge clk);
      chk("t5_res_ready", 64'(res_ready), 64'd1);
      chk("t5_busy", 64'(busy), 64'd1);
      pulse_start();
      @(posedge clk); #1 res_valid = 1'b1;
      wait_done("t5_timeout");
      chk("t5_total", 64'(total_cycles), 64'd5);
      res_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_idle_after", 64'(busy), 64'd0);
      chk("t5_done_once", 64'(done_n), 64'd1);

      // Reset mid-LOAD, then a clean run
      clr_cfg();
      num_seg = 4'd1;
      set_seg(0, 16'h0300, 8, 0);
      pulse_start();
      repeat (4) @(negedge clk);
      chk("t6_loading", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_mem_en", 64'(mem_en), 64'd0);
      chk("t6_mem_addr", 64'(mem_addr), 64'd0);
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_out_data", out_data, 64'd0);
      chk("t6_res_ready", 64'(res_ready), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_result", result, 64'd0);
      chk("t6_total", 64'(total_cycles), 64'd0);
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      simple_run(64'h3C);
      @(negedge clk);
      chk("end_words", 64'(exp_q.size()), 64'd0);
      chk("end_results", 64'(exp_res.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
